// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block.
package scan_decoder_pkg;

    typedef enum logic {
        DRIVE    = 1'b0,
        BLANKING = 1'b1
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_if.sv
// Control/output bundle between the CPU-side logic (master) and scan_decoder (slave).
interface scan_decoder_if #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned N_OUT   = 10,
    parameter int unsigned DWELL_W = 8
) ();

    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               load;
    logic               tick;
    logic [DWELL_W-1:0] dwell;
    logic [N_OUT-1:0]   o;
    logic [SEL_W-1:0]   idx;
    logic               frame;

    modport master (
        output mode, sel, load, tick, dwell,
        input  o, idx, frame
    );

    modport slave (
        input  mode, sel, load, tick, dwell,
        output o, idx, frame
    );

endinterface

// File: rtl/scan_decoder_decode_n.sv
// Combinational binary to active-low one-hot decoder; all ones when disabled or out of range.
module decode_n #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned N_OUT = 10
) (
    input  logic [SEL_W-1:0] code,
    input  logic             enable,
    output logic [N_OUT-1:0] o
);

    // Codes >= N_OUT match no bit, so the output stays all ones.
    always_comb begin
        o = '1;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (enable && (code == SEL_W'(i))) begin
                o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered active-low N-output decoder with a direct (latched code) mode and a
// scan mode that steps through the outputs with programmable dwell and blanking.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned N_OUT   = 10,
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned BLANK   = 1
) (
    input logic         clk,
    input logic         reset,
    scan_decoder_if.slave bus
);

    localparam int unsigned BLANK_W = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(N_OUT - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic               mode_q;
    logic               frame_q, frame_d;
    logic [N_OUT-1:0]   o_q, o_d;
    logic [SEL_W-1:0]   idx_adv;
    logic               wrap;
    logic               code_en;

    always_comb begin
        sel_d       = bus.load ? bus.sel : sel_q;
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        frame_d     = 1'b0;
        wrap        = (idx_q == LAST_IDX);
        idx_adv     = wrap ? '0 : idx_q + 1'b1;

        if (bus.mode == MODE_DIRECT) begin
            // Direct mode shows the code latched before this edge; the FSM stays parked.
            state_d     = DRIVE;
            idx_d       = sel_q;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else if (mode_q != MODE_SCAN) begin
            state_d     = DRIVE;
            idx_d       = '0;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else if (bus.tick) begin
            unique case (state_q)
                DRIVE: begin
                    // >= so a dwell lowered mid-step ends the step instead of stalling.
                    if (dwell_cnt_q >= bus.dwell) begin
                        dwell_cnt_d = '0;
                        if (BLANK > 0) begin
                            state_d = BLANKING;
                        end else begin
                            idx_d   = idx_adv;
                            frame_d = wrap;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                BLANKING: begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        blank_cnt_d = '0;
                        state_d     = DRIVE;
                        idx_d       = idx_adv;
                        frame_d     = wrap;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        code_en = (state_d == DRIVE);
    end

    decode_n #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_decode (
        .code   (idx_d),
        .enable (code_en),
        .o      (o_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DRIVE;
            idx_q       <= '0;
            sel_q       <= '1;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
            mode_q      <= MODE_DIRECT;
            frame_q     <= 1'b0;
            o_q         <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            mode_q      <= bus.mode;
            frame_q     <= frame_d;
            o_q         <= o_d;
        end
    end

    assign bus.o     = o_q;
    assign bus.idx   = idx_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Randomised and directed bench for scan_decoder against a step/tick-count model.
module tb_scan_decoder;
    import scan_decoder_pkg::*;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned N_OUT   = 10;
    localparam int unsigned DWELL_W = 8;
    localparam int unsigned BLANK   = 1;
    localparam int          NO      = N_OUT;
    localparam int          NB      = BLANK;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    scan_decoder_if #(.SEL_W(SEL_W), .N_OUT(N_OUT), .DWELL_W(DWELL_W)) bus ();

    scan_decoder #(
        .SEL_W   (SEL_W),
        .N_OUT   (N_OUT),
        .DWELL_W (DWELL_W),
        .BLANK   (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a scan step is counted in ticks t; the drive phase ends at the tick
    // where t >= dwell, and the step ends BLANK ticks after that.
    int m_sel       = (1 << SEL_W) - 1;
    bit m_prev_scan = 1'b0;
    int m_cur       = 0;
    int m_t         = 0;
    int m_drive_end = -1;
    bit m_frame     = 1'b0;
    int m_idx       = 0;
    int m_low       = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_sel       = (1 << SEL_W) - 1;
            m_prev_scan = 1'b0;
            m_cur       = 0;
            m_t         = 0;
            m_drive_end = -1;
            m_frame     = 1'b0;
            m_idx       = 0;
            m_low       = -1;
        end else begin
            m_frame = 1'b0;
            if (bus.mode == MODE_DIRECT) begin
                m_cur       = 0;
                m_t         = 0;
                m_drive_end = -1;
                m_idx       = m_sel;
                m_low       = (m_sel < NO) ? m_sel : -1;
            end else begin
                if (!m_prev_scan) begin
                    m_cur       = 0;
                    m_t         = 0;
                    m_drive_end = -1;
                end else if (bus.tick) begin
                    if (m_drive_end < 0 && m_t >= int'(bus.dwell)) m_drive_end = m_t + 1;
                    m_t++;
                    if (m_drive_end >= 0 && m_t >= m_drive_end + NB) begin
                        m_frame     = (m_cur == NO - 1);
                        m_cur       = (m_cur + 1) % NO;
                        m_t         = 0;
                        m_drive_end = -1;
                    end
                end
                m_idx = m_cur;
                m_low = (m_drive_end < 0) ? m_cur : -1;
            end
            if (bus.load) m_sel = int'(bus.sel);
            m_prev_scan = bus.mode;
        end
    endtask

    task automatic compare();
        logic [N_OUT-1:0] e;
        e = '1;
        if (m_low >= 0) e[m_low] = 1'b0;
        check("o", 32'(bus.o), 32'(e));
        check("idx", 32'(bus.idx), 32'(m_idx));
        check("frame", 32'(bus.frame), 32'(m_frame));
        check("one_low", 32'($countones(~bus.o) <= 1), 32'd1);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    initial begin
        int first;
        int second;
        int guard;

        bus.mode  = MODE_DIRECT;
        bus.sel   = '0;
        bus.load  = 1'b0;
        bus.tick  = 1'b0;
        bus.dwell = '0;
        repeat (2) @(negedge clk);
        check("rst_o", 32'(bus.o), 32'h3FF);
        check("rst_idx", 32'(bus.idx), 32'd0);
        check("rst_frame", 32'(bus.frame), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Direct mode: 2-clk latency from load.
        bus.sel  = 4'd3;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        check("dir3_o", 32'(bus.o), 32'b11_1111_0111);
        check("dir3_idx", 32'(bus.idx), 32'd3);
        bus.sel  = 4'd12;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        check("dir12_o", 32'(bus.o), 32'h3FF);
        check("dir12_idx", 32'(bus.idx), 32'd12);

        // Scan, dwell 1, tick every clk: 3 clk per output, 30 clk per frame.
        bus.dwell = 8'd1;
        bus.tick  = 1'b1;
        bus.mode  = MODE_SCAN;
        first = -1;
        second = -1;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 1) check("scan_start_o", 32'(bus.o), 32'h3FE);
            if (bus.frame) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check("frame_first", 32'(first), 32'd31);
        check("frame_period", 32'(second - first), 32'd30);

        // Dwell lowered from 5 to 2 while the count is at 3.
        bus.mode = MODE_DIRECT;
        @(negedge clk);
        bus.dwell = 8'd5;
        bus.mode  = MODE_SCAN;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("dw_hold_o", 32'(bus.o), 32'h3FE);
        bus.dwell = 8'd2;
        @(negedge clk);
        check("dw_blank_o", 32'(bus.o), 32'h3FF);
        @(negedge clk);
        check("dw_next_o", 32'(bus.o), 32'h3FD);
        check("dw_next_idx", 32'(bus.idx), 32'd1);

        // Tick every 4th clk, dwell 0: 8 clk per output, 80 clk per frame.
        bus.mode = MODE_DIRECT;
        @(negedge clk);
        bus.mode  = MODE_SCAN;
        bus.dwell = 8'd0;
        first = -1;
        second = -1;
        for (int k = 1; k <= 170; k++) begin
            bus.tick = (k % 4 == 0);
            @(negedge clk);
            if (bus.frame) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check("slow_frame_first", 32'(first), 32'd80);
        check("slow_frame_period", 32'(second - first), 32'd80);

        // Load during scan, then leave scan at idx 6 and come back.
        bus.tick  = 1'b1;
        bus.dwell = 8'd1;
        bus.sel   = 4'd2;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        guard = 0;
        while (!(m_cur == 6 && m_drive_end < 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wait_idx6", 32'(guard < 200), 32'd1);
        check("at_idx6", 32'(bus.idx), 32'd6);
        bus.mode = MODE_DIRECT;
        @(negedge clk);
        check("s2d_o", 32'(bus.o), 32'h3FB);
        check("s2d_idx", 32'(bus.idx), 32'd2);
        bus.mode = MODE_SCAN;
        @(negedge clk);
        check("d2s_o", 32'(bus.o), 32'h3FE);
        check("d2s_frame", 32'(bus.frame), 32'd0);

        // Asynchronous reset while blanking.
        guard = 0;
        while (m_drive_end < 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("wait_blank", 32'(guard < 50), 32'd1);
        bus.sel = 4'd5;
        @(negedge clk);
        guard = 0;
        while (!(m_cur == 2 && m_drive_end >= 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("wait_blank2", 32'(guard < 100), 32'd1);
        check("pre_rst_blank_o", 32'(bus.o), 32'h3FF);
        check("pre_rst_idx", 32'(bus.idx), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_o", 32'(bus.o), 32'h3FF);
        check("async_rst_idx", 32'(bus.idx), 32'd0);
        check("async_rst_frame", 32'(bus.frame), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_o", 32'(bus.o), 32'h3FE);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
            bus.load = ($urandom_range(0, 7) == 0);
            bus.sel  = SEL_W'($urandom_range(0, 15));
            bus.tick = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) bus.dwell = DWELL_W'($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered active-low N-output decoder for arcade select, strobe and matrix-scan generation.
- Direct mode: latches a binary code and drives one output low. Codes at or above N_OUT drive all outputs high, matching the '42-family behaviour.
- Scan mode: an internal FSM steps the active-low output through 0..N_OUT-1, with programmable dwell and anti-ghost blanking.
- Sits between CPU-side address/latch logic and lamp, switch-matrix or digit-strobe consumers.

Parameters:
- SEL_W, 4, width of select code and index. Must satisfy N_OUT <= 2**SEL_W.
- N_OUT, 10, number of decoded outputs, minimum 2.
- DWELL_W, 8, width of the dwell programming input.
- BLANK, 1, number of ticks with all outputs high between scan steps. 0 disables blanking.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- mode, input, 1: 0 = direct, 1 = scan.
- sel, input, SEL_W: direct-mode code.
- load, input, 1: one-cycle strobe that latches sel.
- tick, input, 1: scan step enable, a clock-enable from an external divider.
- dwell, input, DWELL_W: each scan output is held for dwell+1 ticks.
- o, output, N_OUT: decoded outputs, active low.
- idx, output, SEL_W: current scan index, or latched sel in direct mode.
- frame, output, 1: one-clk pulse when the scan wraps to index 0.

Behaviour:
- Reset (async assert, takes effect immediately):
  - o = all ones; idx = 0; frame = 0.
  - Latched sel = all ones, which is out of range, so no output is active.
  - dwell counter = 0; blank counter = 0; FSM = DRIVE.
- All outputs are registered. There is no combinational path from inputs to o, idx or frame.
- Direct mode (mode = 0):
  - The clock edge with load = 1 latches sel.
  - On the following edge, o[sel] = 0 and all other outputs = 1. Latency is 2 clk from load to o; idx follows with the same latency.
  - sel >= N_OUT: o = all ones.
  - Without load, o holds.
  - tick is ignored; frame = 0.
- Scan mode (mode = 1), FSM states DRIVE and BLANKING:
  - DRIVE: o[idx] = 0. The dwell counter increments on each tick.
  - DRIVE, on a tick with counter >= dwell: clear the counter. If BLANK > 0, go to BLANKING; otherwise advance idx and stay in DRIVE.
  - BLANKING: o = all ones; the blank counter increments on each tick. On the tick where it reaches BLANK-1: clear it, advance idx, go to DRIVE.
  - Advance rule: idx = N_OUT-1 wraps to 0 and frame pulses for exactly one clk on that edge; otherwise idx+1.
  - Comparison uses >=, so reducing dwell mid-step ends the current step on the next tick and never stalls.
  - Cycles without tick hold all state.
- Mode transitions:
  - 0 -> 1: the next edge forces idx = 0, DRIVE, counters cleared, o[0] = 0. frame is not pulsed.
  - 1 -> 0: the next edge drives o from the latched sel; the FSM is parked in DRIVE with counters cleared.
  - load during scan mode updates the latch only. It has no visible effect until mode = 0.
  - load and mode toggling in the same cycle: the latch updates and the mode transition rule applies.
- Output invariant: at most one bit of o is low at any time.
- Reset asserted mid-scan or mid-blank returns everything to reset values immediately. Operation resumes on the first edge after deassert, per the mode rules.

Decomposition:
- Package scan_decoder_pkg holds the FSM state enum (DRIVE, BLANKING) and the mode constants MODE_DIRECT = 0 and MODE_SCAN = 1.
- One sub-module, decode_n: a parametrised combinational binary-to-active-low one-hot decoder.
  - Parameters: SEL_W and N_OUT. Inputs: code and enable.
  - Output is all ones when enable = 0 or code >= N_OUT.
  - scan_decoder registers its output.

Test Plan:
- Reset, then direct mode, load with sel = 3 -> 2 clk later o = 10'b11_1111_0111 and idx = 3. Then sel = 12 -> o = 10'h3FF.
- Scan mode, dwell = 1, BLANK = 1, tick every cycle -> each o[i] is low 2 clk, then 1 clk all-high. Sequence is 0..9, then 0. frame pulses once on the 9 -> 0 advance; period 30 clk.
- Scan mode, dwell = 5; at count 3, change dwell to 2 -> the step ends on the next tick and no stall occurs.
- Scan with tick asserted every 4th clk -> timing scales by 4 and state holds on non-tick clk.
- Switch from scan (idx = 6) to direct with latched sel = 2 -> next edge o[2] = 0. Switch back -> o[0] = 0 and frame stays 0.
- Assert reset mid-BLANKING asynchronously -> o = all ones immediately, idx = 0. The bench checks the one-low-max invariant on every cycle.
